// File: rtl/operand_capture_if.sv
// Operand/select pins, enable and carry button into the capture stage; committed operands and valid pulse out.
interface operand_capture_if;
    logic       ena;
    logic [7:0] sw;
    logic [4:0] sw2;
    logic [2:0] sel;
    logic       btnC;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [2:0] sel_q;
    logic       cin_q;
    logic       valid;

    modport master (
        output ena, sw, sw2, sel, btnC,
        input  a_q, b_q, sel_q, cin_q, valid
    );

    modport slave (
        input  ena, sw, sw2, sel, btnC,
        output a_q, b_q, sel_q, cin_q, valid
    );
endinterface

// File: rtl/operand_capture.sv
// Syncs {sel,sw2,sw}, commits them after SETTLE_CYCLES stable cycles (SETTLE_CYCLES+3 edges, one-cycle valid, no backpressure),
// and debounces btnC into cin_q (DB_CYCLES+2 edges). OPCAP_SIGN_EXT_EN sign-extends b_q instead of zero-extending.
module operand_capture #(
    parameter int SETTLE_CYCLES = 16,
    parameter int DB_CYCLES     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_capture_if.slave bus
);
    localparam int CW = $clog2(SETTLE_CYCLES) + 1;
    localparam int DW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DB_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMMIT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_sync1;
    logic [15:0]   r_s;
    logic          r_bsync1;
    logic          r_bs;
    logic [15:0]   r_p;
    logic [15:0]   w_p_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [DW-1:0] r_dcnt;
    logic          w_load;
    logic [15:0]   w_h;
    logic [7:0]    r_a;
    logic [4:0]    r_b_raw;
    logic [2:0]    r_sel;
    logic          r_cin;
    logic          r_valid;

    assign w_h = {r_sel, r_b_raw, r_a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_s      <= '0;
            r_bsync1 <= 1'b0;
            r_bs     <= 1'b0;
        end else begin
            r_sync1  <= {bus.sel, bus.sw2, bus.sw};
            r_s      <= r_sync1;
            r_bsync1 <= bus.btnC;
            r_bs     <= r_bsync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_p     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // cnt stops at CNT_MAX because reaching it always leaves SETTLE
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_s != w_h) begin
                    w_state_nxt = ST_SETTLE;
                    w_p_nxt     = r_s;
                    w_cnt_nxt   = CW'(1);
                end
            end
            ST_SETTLE: begin
                if (r_s != r_p) begin
                    w_p_nxt   = r_s;
                    w_cnt_nxt = CW'(1);
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_load      = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!bus.ena) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_load      = 1'b0;
        end
    end

    // A commit that lands back on the held value reloads silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b_raw <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_load && (r_p != w_h);
            if (w_load) begin
                r_a     <= r_p[7:0];
                r_b_raw <= r_p[12:8];
                r_sel   <= r_p[15:13];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cin  <= 1'b0;
            r_dcnt <= '0;
        end else if (r_bs == r_cin) begin
            r_dcnt <= '0;
        end else if (r_dcnt == DCNT_MAX) begin
            r_cin  <= r_bs;
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + DW'(1);
        end
    end

    assign bus.a_q   = r_a;
    assign bus.sel_q = r_sel;
    assign bus.cin_q = r_cin;
    assign bus.valid = r_valid;
`ifdef OPCAP_SIGN_EXT_EN
    assign bus.b_q   = {{3{r_b_raw[4]}}, r_b_raw};
`else
    assign bus.b_q   = {3'b000, r_b_raw};
`endif
endmodule

// File: tb/tb_operand_capture.sv
// Scoreboard bench for operand_capture: stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_operand_capture;
    localparam int S  = 4;
    localparam int DB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    operand_capture_if bus();

    operand_capture #(.SETTLE_CYCLES(S), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] v;
    } exp_t;

    exp_t        expq[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] held;
    logic [15:0] cur;
    int          last_chg;
    bit          done;
    logic        db_smp [DB+3];
    logic        cin_m;

    function automatic logic [7:0] bext(input logic [4:0] b);
`ifdef OPCAP_SIGN_EXT_EN
        return {{3{b[4]}}, b};
`else
        return {3'b000, b};
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // carry-in reference: toggles once the DB+1 samples seen two edges ago all disagree with it
    initial forever begin
        bit all_diff;
        @(posedge clk);
        if (!rst_n) begin
            foreach (db_smp[i]) db_smp[i] = 1'b0;
            cin_m = 1'b0;
        end else begin
            for (int i = DB + 2; i > 0; i--) db_smp[i] = db_smp[i-1];
            db_smp[0] = bus.btnC;
            all_diff = 1'b1;
            for (int i = 2; i <= DB + 2; i++) if (db_smp[i] == cin_m) all_diff = 1'b0;
            if (all_diff) cin_m = ~cin_m;
        end
    end

    initial begin
        exp_t e;
        logic prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 1'b0;
            end else begin
                n_cmp++;
                if (bus.cin_q !== cin_m) begin
                    n_err++;
                    $display("FAIL cin_q @%0d: got %0b expected %0b", cyc, bus.cin_q, cin_m);
                end
                if (bus.valid === 1'b1) begin
                    n_cmp++;
                    if (prev_vld) begin
                        n_err++;
                        $display("FAIL valid_twice @%0d: valid high on consecutive cycles, expected a single pulse", cyc);
                    end
                    n_cmp++;
                    if (expq.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_valid @%0d: got valid=1 expected 0 (a=%0h)", cyc, bus.a_q);
                    end else begin
                        e = expq.pop_front();
                        if (e.t != cyc || bus.a_q !== e.v[7:0] || bus.b_q !== bext(e.v[12:8]) ||
                            bus.sel_q !== e.v[15:13]) begin
                            n_err++;
                            $display("FAIL commit: got cyc=%0d a=%0h b=%0h sel=%0h expected cyc=%0d a=%0h b=%0h sel=%0h",
                                     cyc, bus.a_q, bus.b_q, bus.sel_q, e.t, e.v[7:0], bext(e.v[12:8]), e.v[15:13]);
                        end
                    end
                end else if (expq.size() != 0 && expq[0].t < cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_valid @%0d: got no valid, expected commit of %0h at cycle %0d",
                             cyc, expq[0].v, expq[0].t);
                    expq.pop_front();
                end
                prev_vld = bus.valid;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic check_hold(input string name);
        check({name, "_a"},   32'(bus.a_q),   32'(held[7:0]));
        check({name, "_b"},   32'(bus.b_q),   32'(bext(held[12:8])));
        check({name, "_sel"}, 32'(bus.sel_q), 32'(held[15:13]));
    endtask

    task automatic set_pins(input logic [15:0] v);
        bus.sw   = v[7:0];
        bus.sw2  = v[12:8];
        bus.sel  = v[15:13];
        cur      = v;
        last_chg = cyc + 1;
    endtask

    task automatic expect_commit(input string name, input int tc);
        if (cur != held) expq.push_back('{tc, cur});
        while (cyc < tc + 2) tick(1);
        if (cur == held) check_hold(name);
        held = cur;
        tick(2);
    endtask

    task automatic finish_burst(input string name);
        expect_commit(name, last_chg + S + 3);
    endtask

    initial begin
        logic [15:0] nv;
        int          nchg;
        bus.ena  = 1'b1;
        bus.sw   = '0;
        bus.sw2  = '0;
        bus.sel  = '0;
        bus.btnC = 1'b0;
        held     = '0;
        cur      = '0;
        last_chg = 0;
        done     = 1'b0;
        tick(3);
        check("rst_a",     32'(bus.a_q),   32'h0);
        check("rst_b",     32'(bus.b_q),   32'h0);
        check("rst_sel",   32'(bus.sel_q), 32'h0);
        check("rst_cin",   32'(bus.cin_q), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // 3-sample glitch must be filtered; a held press lands 6 edges after first sampling
        bus.btnC = 1'b1;
        tick(3);
        bus.btnC = 1'b0;
        tick(10);
        check("db_glitch", 32'(bus.cin_q), 32'h0);
        bus.btnC = 1'b1;
        tick(6);
        check("db_early", 32'(bus.cin_q), 32'h0);
        tick(1);
        check("db_level", 32'(bus.cin_q), 32'h1);
        tick(4);
        bus.btnC = 1'b0;
        tick(10);
        fork
            while (!done) begin
                bus.btnC = ~bus.btnC;
                tick($urandom_range(8, 1));
            end
        join_none

        set_pins({3'b101, 5'h1F, 8'h3C});
        finish_burst("basic");

        set_pins({3'b101, 5'h1F, 8'hA5});
        tick(3);
        rst_n = 1'b0;
        #1;
        check("midrst_a",     32'(bus.a_q),   32'h0);
        check("midrst_b",     32'(bus.b_q),   32'h0);
        check("midrst_sel",   32'(bus.sel_q), 32'h0);
        check("midrst_valid", 32'(bus.valid), 32'h0);
        expq.delete();
        held = '0;
        tick(2);
        rst_n = 1'b1;
        expect_commit("after_rst", cyc + 1 + S + 3);

        for (int i = 0; i < 5; i++) begin
            set_pins({cur[15:8], 7'h0, i[0]});
            tick(2);
        end
        set_pins({cur[15:8], 8'h01});
        finish_burst("bounce_restart");

        set_pins({cur[15:8], 8'h10});
        finish_burst("pre_bounce_back");
        set_pins({cur[15:8], 8'h11});
        tick(1);
        set_pins({cur[15:8], 8'h10});
        finish_burst("bounce_back");

        bus.ena = 1'b0;
        set_pins({cur[15:8], 8'hFF});
        tick(20);
        check_hold("freeze");
        bus.ena = 1'b1;
        expect_commit("unfreeze", cyc + S + 2);

        for (int n = 0; n < 40; n++) begin
            nchg = int'($urandom_range(4, 1));
            for (int c = 0; c < nchg; c++) begin
                case ($urandom_range(2, 0))
                    0:       nv = cur ^ (16'h1 << $urandom_range(15, 0));
                    1:       nv = held;
                    default: nv = cur ^ 16'($urandom_range(16'hFFFF, 1));
                endcase
                if (nv == cur) nv = cur ^ 16'h8000;
                set_pins(nv);
                if (c < nchg - 1) tick($urandom_range(S, 1));
            end
            finish_burst("rand");
        end

        tick(10);
        done = 1'b1;
        n_cmp++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d pending commits expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
